// File: rtl/wb_guard_pkg.sv
// ---------------------------------------------------------------------------
// wb_guard_pkg
// Shared definitions for the Wishbone timeout guard:
//   - guard_state_e : FSM state encoding (IDLE, REQ, RESP)
//   - WB_GUARD_ERR_DATA : default read data returned when the core times out
//   - sat_inc16() : saturating 16-bit increment used by the timeout counter
// ---------------------------------------------------------------------------
package wb_guard_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } guard_state_e;

   localparam logic [31:0] WB_GUARD_ERR_DATA = 32'hDEAD_BEEF;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      logic [15:0] res;
      if (val == 16'hFFFF) begin
         res = val;
      end else begin
         res = val + 16'd1;
      end
      return res;
   endfunction

endpackage : wb_guard_pkg

// File: rtl/wb_timeout_guard.sv
// ---------------------------------------------------------------------------
// wb_timeout_guard
// Wishbone classic pipeline stage between an upstream bridge (s_* side) and a
// downstream core (m_* side). Each request is registered and forwarded; if
// the core does not answer within TIMEOUT_CYCLES cycles the cycle is dropped
// and the master receives an error response carrying ERR_DATA, so a hung core
// can never stall the upstream bus.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   s_adr_i/dat_i/sel_i/we_i  request from the upstream master
//   s_cyc_i, s_stb_i          upstream cycle / strobe
//   s_dat_o, s_ack_o, s_err_o response to the master (all registered)
//   m_adr_o/dat_o/sel_o/we_o  registered request to the core
//   m_cyc_o, m_stb_o          cycle / strobe to the core (registered)
//   m_dat_i, m_ack_i, m_err_i response from the core
//   timeout_o                 one-cycle pulse per timeout (during RESP)
//   err_count_o               saturating count of timeouts
//
// All outputs come straight from flops: there is no combinational path from
// s_* inputs to m_* outputs or from m_* inputs to s_* outputs.
// ---------------------------------------------------------------------------
module wb_timeout_guard
   import wb_guard_pkg::*;
#(
   parameter int unsigned          ADR_WIDTH      = 32,
   parameter int unsigned          DAT_WIDTH      = 32,
   parameter int unsigned          TIMEOUT_CYCLES = 256,
   parameter logic [DAT_WIDTH-1:0] ERR_DATA       = DAT_WIDTH'(WB_GUARD_ERR_DATA),
   parameter bit                   ACK_ON_ERR     = 1'b1
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   // upstream (slave) side
   input  logic [ADR_WIDTH-1:0]   s_adr_i,
   input  logic [DAT_WIDTH-1:0]   s_dat_i,
   input  logic [DAT_WIDTH/8-1:0] s_sel_i,
   input  logic                   s_we_i,
   input  logic                   s_cyc_i,
   input  logic                   s_stb_i,
   output logic [DAT_WIDTH-1:0]   s_dat_o,
   output logic                   s_ack_o,
   output logic                   s_err_o,
   // downstream (master) side
   output logic [ADR_WIDTH-1:0]   m_adr_o,
   output logic [DAT_WIDTH-1:0]   m_dat_o,
   output logic [DAT_WIDTH/8-1:0] m_sel_o,
   output logic                   m_we_o,
   output logic                   m_cyc_o,
   output logic                   m_stb_o,
   input  logic [DAT_WIDTH-1:0]   m_dat_i,
   input  logic                   m_ack_i,
   input  logic                   m_err_i,
   // diagnostics
   output logic                   timeout_o,
   output logic [15:0]            err_count_o
);

   // Counter value in the last REQ cycle before a timeout is declared.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   guard_state_e           state_q, state_d;
   logic [ADR_WIDTH-1:0]   m_adr_q, m_adr_d;
   logic [DAT_WIDTH-1:0]   m_dat_q, m_dat_d;
   logic [DAT_WIDTH/8-1:0] m_sel_q, m_sel_d;
   logic                   m_we_q, m_we_d;
   logic                   m_cyc_q, m_cyc_d;   // drives both m_cyc_o and m_stb_o
   logic [15:0]            cnt_q, cnt_d;
   logic [DAT_WIDTH-1:0]   s_dat_q, s_dat_d;
   logic                   s_ack_q, s_ack_d;
   logic                   s_err_q, s_err_d;
   logic                   timeout_q, timeout_d;
   logic [15:0]            err_count_q, err_count_d;

   // Next-state and registered-output logic for the guard FSM.
   // The response flops are loaded on the REQ->RESP edge so that they are
   // visible for exactly the one RESP cycle, then cleared on RESP->IDLE.
   always_comb begin
      state_d     = state_q;
      m_adr_d     = m_adr_q;
      m_dat_d     = m_dat_q;
      m_sel_d     = m_sel_q;
      m_we_d      = m_we_q;
      m_cyc_d     = m_cyc_q;
      cnt_d       = cnt_q;
      s_dat_d     = s_dat_q;
      s_ack_d     = 1'b0;
      s_err_d     = 1'b0;
      timeout_d   = 1'b0;
      err_count_d = err_count_q;

      case (state_q)
         IDLE: begin
            m_cyc_d = 1'b0;
            if (s_cyc_i && s_stb_i) begin
               m_adr_d = s_adr_i;
               m_dat_d = s_dat_i;
               m_sel_d = s_sel_i;
               m_we_d  = s_we_i;
               m_cyc_d = 1'b1;
               cnt_d   = 16'd0;
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end

         REQ: begin
            if (!s_cyc_i) begin
               // Master abandoned the cycle: drop the core side silently.
               m_cyc_d = 1'b0;
               state_d = IDLE;
            end else if (m_ack_i || m_err_i) begin
               // Error wins when the core raises ack and err together.
               s_dat_d = m_dat_i;
               s_err_d = m_err_i;
               s_ack_d = m_err_i ? ACK_ON_ERR : 1'b1;
               m_cyc_d = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               s_dat_d     = ERR_DATA;
               s_err_d     = 1'b1;
               s_ack_d     = ACK_ON_ERR;
               timeout_d   = 1'b1;
               err_count_d = sat_inc16(err_count_q);
               m_cyc_d     = 1'b0;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         RESP: begin
            m_cyc_d = 1'b0;
            state_d = IDLE;
         end

         default: begin
            m_cyc_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         m_adr_q     <= {ADR_WIDTH{1'b0}};
         m_dat_q     <= {DAT_WIDTH{1'b0}};
         m_sel_q     <= {(DAT_WIDTH/8){1'b0}};
         m_we_q      <= 1'b0;
         m_cyc_q     <= 1'b0;
         cnt_q       <= 16'd0;
         s_dat_q     <= {DAT_WIDTH{1'b0}};
         s_ack_q     <= 1'b0;
         s_err_q     <= 1'b0;
         timeout_q   <= 1'b0;
         err_count_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         m_adr_q     <= m_adr_d;
         m_dat_q     <= m_dat_d;
         m_sel_q     <= m_sel_d;
         m_we_q      <= m_we_d;
         m_cyc_q     <= m_cyc_d;
         cnt_q       <= cnt_d;
         s_dat_q     <= s_dat_d;
         s_ack_q     <= s_ack_d;
         s_err_q     <= s_err_d;
         timeout_q   <= timeout_d;
         err_count_q <= err_count_d;
      end
   end

   assign m_adr_o     = m_adr_q;
   assign m_dat_o     = m_dat_q;
   assign m_sel_o     = m_sel_q;
   assign m_we_o      = m_we_q;
   assign m_cyc_o     = m_cyc_q;
   assign m_stb_o     = m_cyc_q;
   assign s_dat_o     = s_dat_q;
   assign s_ack_o     = s_ack_q;
   assign s_err_o     = s_err_q;
   assign timeout_o   = timeout_q;
   assign err_count_o = err_count_q;

endmodule : wb_timeout_guard
